// File: rtl/hex_count_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hex_count_ctrl_pkg
// Shared definitions for the hex counter front end.
//   step_t    : what the counter does on a given clock edge
//   pick_step : resolves the conditioned button pulses and the auto-count
//               tick into a single step, highest priority first
//               (clear, inc+dec cancel, inc, dec, tick).
// ---------------------------------------------------------------------------
package hex_count_ctrl_pkg;

    typedef enum logic [2:0] {
        STEP_NONE,
        STEP_CLR,
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN
    } step_t;

    // A manual step always beats the tick; the tick is simply dropped.
    function automatic step_t pick_step(
        input logic clr,
        input logic inc,
        input logic dec,
        input logic tick,
        input logic down
    );
        step_t s;
        if (clr)             s = STEP_CLR;
        else if (inc && dec) s = STEP_HOLD;
        else if (inc)        s = STEP_UP;
        else if (dec)        s = STEP_DOWN;
        else if (tick)       s = down ? STEP_DOWN : STEP_UP;
        else                 s = STEP_NONE;
        return s;
    endfunction

endpackage

// File: rtl/hex_count_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Conditions one raw, asynchronous, active-high board button.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   raw   : raw button input (asynchronous to clk)
//   level : debounced button level
//   press : registered one-cycle pulse on each accepted 0->1 of level
// The raw input goes through a 2-flop synchroniser. The synchronised level
// must differ from the accepted level for DEBOUNCE_CYCLES consecutive cycles
// before it is taken over; any return to the accepted level restarts the
// count. Holding the button gives one pulse only; release gives none.
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_lvl;
    logic          stable;
    logic          stable_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta   <= 1'b0;
            sync_lvl    <= 1'b0;
            stable      <= 1'b0;
            stable_prev <= 1'b0;
            cnt         <= '0;
            press       <= 1'b0;
        end else begin
            sync_meta   <= raw;
            sync_lvl    <= sync_meta;
            stable_prev <= stable;
            // Pulse follows the accepted level by one cycle, rising edge only.
            press       <= stable & ~stable_prev;

            if (sync_lvl == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync_lvl;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = stable;

endmodule

// File: rtl/hex_count_ctrl.sv
// ---------------------------------------------------------------------------
// hex_count_ctrl
// Produces the registered 16-bit count shown by the 4-digit hex display.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   btn_inc : raw increment button (async, active-high)
//   btn_dec : raw decrement button (async, active-high)
//   btn_clr : raw clear button (async, active-high)
//   run     : auto-count enable switch (async, synchronised here)
//   dir     : auto-count direction, 0 = up, 1 = down (synchronised here)
//   data    : current count, modulo 2^16
//   carry   : one-cycle pulse after an increment from FFFF
//   borrow  : one-cycle pulse after a decrement from 0000
// Buttons are conditioned by btn_debounce. A prescaler produces one tick
// every PRESCALE cycles while run is on. Clear also restarts the prescaler.
// ---------------------------------------------------------------------------
module hex_count_ctrl
    import hex_count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PRESCALE        = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_clr,
    input  logic        run,
    input  logic        dir,
    output logic [15:0] data,
    output logic        carry,
    output logic        borrow
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic          inc_press;
    logic          dec_press;
    logic          clr_press;
    // Debounced levels are available for other consumers but not needed here.
    logic [2:0]    btn_levels_unused;

    logic          run_meta;
    logic          run_sync;
    logic          dir_meta;
    logic          dir_sync;
    logic [PW-1:0] presc;
    logic          tick;
    step_t         step;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_inc),
        .level (btn_levels_unused[0]),
        .press (inc_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_dec),
        .level (btn_levels_unused[1]),
        .press (dec_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_clr),
        .level (btn_levels_unused[2]),
        .press (clr_press)
    );

    always_comb begin
        tick = run_sync && (presc == PRESC_MAX);
        step = pick_step(clr_press, inc_press, dec_press, tick, dir_sync);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_meta <= 1'b0;
            run_sync <= 1'b0;
            dir_meta <= 1'b0;
            dir_sync <= 1'b0;
            presc    <= '0;
            data     <= 16'h0000;
            carry    <= 1'b0;
            borrow   <= 1'b0;
        end else begin
            run_meta <= run;
            run_sync <= run_meta;
            dir_meta <= dir;
            dir_sync <= dir_meta;

            // The prescaler keeps wrapping even when a manual step swallows
            // the tick; only clear or run going low restarts it.
            if (step == STEP_CLR || !run_sync || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end

            carry  <= 1'b0;
            borrow <= 1'b0;
            case (step)
                STEP_CLR: begin
                    data <= 16'h0000;
                end
                STEP_UP: begin
                    data  <= data + 16'd1;
                    carry <= (data == 16'hFFFF);
                end
                STEP_DOWN: begin
                    data   <= data - 16'd1;
                    borrow <= (data == 16'h0000);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_count_ctrl
// Directed bench for hex_count_ctrl with DEBOUNCE_CYCLES=4, PRESCALE=8.
// A behavioural model predicts data/carry/borrow from the raw input history:
// a button level is accepted once its synchronised samples have disagreed
// with the accepted level for DEBOUNCE_CYCLES samples in a row, and the count
// moves two edges later. Auto-count ticks come from a modulo-PRESCALE phase.
// ---------------------------------------------------------------------------
module tb_hex_count_ctrl;

    localparam int D = 4;
    localparam int P = 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic        btn_clr = 1'b0;
    logic        run = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] data;
    logic        carry;
    logic        borrow;

    always #5 clk = ~clk;

    hex_count_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .PRESCALE       (P)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_inc (btn_inc),
        .btn_dec (btn_dec),
        .btn_clr (btn_clr),
        .run     (run),
        .dir     (dir),
        .data    (data),
        .carry   (carry),
        .borrow  (borrow)
    );

    int checks = 0;
    int errors = 0;
    int carry_seen = 0;
    int borrow_seen = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int data_m = 0;
    bit carry_m = 1'b0;
    bit borrow_m = 1'b0;
    bit hist[3][$];
    bit run_h[$];
    bit dir_h[$];
    bit stable_m[3];
    int press_at[3];
    int edge_n = 0;
    int phase = 0;

    task automatic reset_model();
        data_m   = 0;
        carry_m  = 1'b0;
        borrow_m = 1'b0;
        phase    = 0;
        for (int b = 0; b < 3; b++) begin
            hist[b].delete();
            for (int i = 0; i < D + 2; i++) hist[b].push_back(1'b0);
            stable_m[b] = 1'b0;
            press_at[b] = -1;
        end
        run_h.delete();
        dir_h.delete();
        repeat (2) begin
            run_h.push_back(1'b0);
            dir_h.push_back(1'b0);
        end
    endtask

    initial reset_model();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reset_model();
        end else begin
            bit run_s, dir_s, p_inc, p_dec, p_clr, tick, all_diff;
            bit raw_now[3];
            int delta;
            edge_n++;
            raw_now[0] = btn_inc;
            raw_now[1] = btn_dec;
            raw_now[2] = btn_clr;
            // switch value as seen two samples late through the synchroniser
            run_s = run_h[run_h.size() - 2];
            dir_s = dir_h[dir_h.size() - 2];
            p_inc = (press_at[0] == edge_n);
            p_dec = (press_at[1] == edge_n);
            p_clr = (press_at[2] == edge_n);
            tick  = run_s && (phase == P - 1);

            delta = 0;
            if (!p_clr) begin
                if (p_inc && p_dec) delta = 0;
                else if (p_inc)     delta = 1;
                else if (p_dec)     delta = -1;
                else if (tick)      delta = dir_s ? -1 : 1;
            end
            carry_m  = (delta == 1) && (data_m == 65535);
            borrow_m = (delta == -1) && (data_m == 0);
            data_m   = p_clr ? 0 : ((data_m + delta + 65536) % 65536);
            phase    = (!run_s || p_clr) ? 0 : (phase + 1) % P;

            // hist holds raw samples up to the previous edge; indices 1..D
            // are the synchronised samples the debouncer has judged so far.
            for (int b = 0; b < 3; b++) begin
                all_diff = 1'b1;
                for (int i = 1; i <= D; i++)
                    if (hist[b][i] == stable_m[b]) all_diff = 1'b0;
                if (all_diff) begin
                    stable_m[b] = ~stable_m[b];
                    if (stable_m[b]) press_at[b] = edge_n + 2;
                end
                hist[b].push_back(raw_now[b]);
                void'(hist[b].pop_front());
            end
            run_h.push_back(run);
            void'(run_h.pop_front());
            dir_h.push_back(dir);
            void'(dir_h.pop_front());
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        check("data", data, 16'(data_m));
        check("carry", {15'b0, carry}, {15'b0, carry_m});
        check("borrow", {15'b0, borrow}, {15'b0, borrow_m});
        if (carry)  carry_seen++;
        if (borrow) borrow_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_inc = v;
            1: btn_dec = v;
            default: btn_clr = v;
        endcase
    endtask

    task automatic press_btn(input int b);
        @(negedge clk);
        set_btn(b, 1'b1);
        cycles(10);
        set_btn(b, 1'b0);
        cycles(12);
    endtask

    // Hold btn_inc from before edge N and pin the exact step edge N+D+3.
    task automatic held_inc_latency(input string tag);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 6) check({tag, "_before"}, data, 16'h0000);
            if (k == 7) check({tag, "_edge7"}, data, 16'h0001);
        end
        check({tag, "_single"}, data, 16'h0001);
        check({tag, "_model"}, 16'(data_m), 16'h0001);
        @(negedge clk);
        btn_inc = 1'b0;
        cycles(12);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        cycles(3);
        check("rst_data", data, 16'h0000);
        check("rst_carry", {15'b0, carry}, 16'h0000);
        check("rst_borrow", {15'b0, borrow}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        // clean held increment
        @(negedge clk);
        btn_inc = 1'b1;
        held_inc_latency("inc_clean");

        // bouncing increment, then held
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            btn_inc = ((i / 2) % 2) == 0;
            @(negedge clk);
        end
        check("bounce_nostep", data, 16'h0001);
        btn_inc = 1'b1;
        cycles(12);
        check("bounce_held", data, 16'h0002);
        btn_inc = 1'b0;
        cycles(12);

        // clear, then three decrements through zero
        press_btn(2);
        check("clr", data, 16'h0000);
        press_btn(1);
        check("dec1", data, 16'hFFFF);
        check("dec1_model", 16'(data_m), 16'hFFFF);
        press_btn(1);
        check("dec2", data, 16'hFFFE);
        press_btn(1);
        check("dec3", data, 16'hFFFD);
        check("borrow_count", 16'(borrow_seen), 16'd1);

        // auto-count up: run high for 36 samples gives 4 ticks
        press_btn(2);
        @(negedge clk);
        run = 1'b1;
        cycles(36);
        run = 1'b0;
        cycles(12);
        check("auto_up", data, 16'h0004);
        check("auto_up_model", 16'(data_m), 16'h0004);

        // auto-count wrap FFFF -> 0000 with carry
        press_btn(2);
        press_btn(1);
        check("preload", data, 16'hFFFF);
        check("no_carry_yet", 16'(carry_seen), 16'd0);
        @(negedge clk);
        run = 1'b1;
        cycles(12);
        run = 1'b0;
        cycles(6);
        check("auto_wrap", data, 16'h0000);
        check("carry_count", 16'(carry_seen), 16'd1);

        // auto-count down: two ticks from 0000
        @(negedge clk);
        dir = 1'b1;
        cycles(4);
        run = 1'b1;
        cycles(20);
        run = 1'b0;
        cycles(6);
        check("auto_down", data, 16'hFFFE);
        dir = 1'b0;
        cycles(4);

        // inc and dec together cancel
        @(negedge clk);
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        cycles(10);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        cycles(12);
        check("inc_dec_cancel", data, 16'hFFFE);

        // clear wins over inc
        @(negedge clk);
        btn_inc = 1'b1;
        btn_clr = 1'b1;
        cycles(10);
        btn_inc = 1'b0;
        btn_clr = 1'b0;
        cycles(12);
        check("clr_over_inc", data, 16'h0000);

        // count to 0x1234, then reset mid-press
        @(negedge clk);
        run = 1'b1;
        n = 0;
        while (data != 16'h1234 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("reach_1234", data, 16'h1234);
        btn_inc = 1'b1;
        cycles(3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        check("async_rst_data", data, 16'h0000);
        check("async_rst_carry", {15'b0, carry}, 16'h0000);
        check("async_rst_borrow", {15'b0, borrow}, 16'h0000);
        cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        held_inc_latency("rst_held");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
